dp_decode_pipe: RTL and testbench
=================================

DP_DECODE_PIPE -- requirements
Module: dp_decode_pipe

Interface
REQ-001 Parameter STAGES, default 2, meaning output register stages, legal range 1..4.
REQ-002 Parameter CNT_W, default 8, meaning width of the illegal-op counter.
REQ-003 Port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, meaning reset: synchronous, active-low (0 = reset).
REQ-005 Port in_valid, input, 1, meaning an instruction is offered.
REQ-006 Port in_ready, output, 1, meaning the block accepts this cycle.
REQ-007 Port Funct, input, 6, meaning the instruction Funct field: [5]=I, [4:1]=cmd, [0]=S.
REQ-008 Port ALUOp, input, 1, meaning 1 = data-processing instruction.
REQ-009 Port out_valid, input-side consumer handshake: output, 1, meaning the decode result is valid.
REQ-010 Port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-011 Port ALUControl, output, 4, meaning the ALU operation code.
REQ-012 Port FlagW, output, 2, meaning the flag-write enables: [1]=NZ, [0]=CV.
REQ-013 Port NoWrite, output, 1, meaning the destination register write is suppressed.
REQ-014 Port Illegal, output, 1, meaning the result is an unimplemented opcode.
REQ-015 Port illegal_cnt_clr, input, 1, meaning synchronous counter clear.
REQ-016 Port illegal_cnt, output, CNT_W, meaning the saturating count of accepted illegal ops.

Function
REQ-017 When ALUOp=1, cmd decodes to ALUControl as follows: AND/TST=0010, EOR/TEQ=0111, SUB/CMP=0001, RSB=0110, ADD/CMN=0000, ADC=0100, SBC=0101, ORR=0011, MOV=1001, BIC=1000, MVN=1010.
REQ-018 Arithmetic ops are ADD, SUB, RSB, ADC, SBC, CMP and CMN; all others are logical.
REQ-019 For non-compare ops: FlagW[1]=S; FlagW[0]=S & arithmetic; NoWrite=0.
REQ-020 TST, TEQ, CMP and CMN with S=1 give NoWrite=1 and FlagW[1]=1, and FlagW[0]=1 for CMP/CMN only (0 for TST/TEQ).
REQ-021 Illegal decode occurs for cmd=0111 (RSC) or for TST/TEQ/CMP/CMN with S=0.
REQ-022 An illegal decode gives ALUControl=0000, FlagW=00, NoWrite=1, Illegal=1; no X on any output.
REQ-023 When ALUOp=0, the decode gives ALUControl=0000, FlagW=00, NoWrite=0, Illegal=0, regardless of Funct.
REQ-024 The decode is combinational into stage 0 and is registered through STAGES elastic stages, each holding a valid bit and a payload.
REQ-025 A stage loads when it is empty or its contents advance this cycle; out_valid/outputs come from the last stage.
REQ-026 in_ready = NOT stage0_valid OR stage0 advances; it is combinational from out_ready through the stages.
REQ-027 Latency is STAGES cycles from the accepting in_valid&in_ready edge to out_valid with out_ready held at 1; throughput is 1 per cycle.
REQ-028 With out_valid=1 and out_ready=0, the outputs are held stable; no result is dropped or duplicated; and ordering is preserved.
REQ-029 When the pipe is full and out_ready=1, an input is accepted in the same cycle the output is taken.
REQ-030 illegal_cnt increments by 1 on each accepted input (in_valid&in_ready) that decodes illegal, and saturates at 2^CNT_W-1.
REQ-031 illegal_cnt_clr has priority: an increment in the same cycle is lost, and the counter becomes 0.
REQ-032 When out_valid=0, payload outputs are don't-care for consumers but still driven to known values.

Reset
REQ-033 While reset=0 at a clk edge, all stage valid bits clear, out_valid=0, illegal_cnt=0, and payload registers=0 (ALUControl=0000, FlagW=00, NoWrite=0, Illegal=0).
REQ-034 Reset asserted mid-operation discards all in-flight results, and no result from before reset appears afterwards.
REQ-035 in_ready=0 while reset=0; in_ready=1 in the first cycle after release.

Verification
REQ-036 With STAGES=2 and out_ready=1, ALUOp=1 and Funct=001001 (ADD,S) -> two cycles later out_valid=1, ALUControl=0000, FlagW=11, NoWrite=0, Illegal=0.
REQ-037 Funct=010101 (CMP,S) -> ALUControl=0001, FlagW=11, NoWrite=1; Funct=010001 (TST,S) -> ALUControl=0010, FlagW=10, NoWrite=1.
REQ-038 Funct=001110 (RSC) and Funct=010100 (CMP, S=0) -> Illegal=1, ALUControl=0000, FlagW=00, NoWrite=1, illegal_cnt=2.
REQ-039 Stream of 6 ops with out_ready=0 for cycles 3..7 -> in_ready falls after STAGES results are held, outputs are stable, and all 6 emerge in order with none lost.
REQ-040 With CNT_W=2, 5 illegal ops accepted -> illegal_cnt=3; clr and illegal accept in the same cycle -> illegal_cnt=0.
REQ-041 reset=0 with the pipe full -> next cycle out_valid=0 and illegal_cnt=0; after release, the first result out equals the first new input.

Source files
------------

// File: rtl/dp_decode_pipe.sv
// ---------------------------------------------------------------------------
// dp_decode_pipe
//
// Purpose
//   Data-processing instruction decoder followed by an elastic output pipe.
//   The Funct/ALUOp decode is purely combinational and feeds stage 0; the
//   result then moves through STAGES register stages (valid bit + payload).
//   The pipe also keeps a saturating count of accepted illegal opcodes.
//
// Parameters
//   STAGES           number of output register stages, legal range 1..4
//   CNT_W            width of the illegal-op counter
//
// Ports
//   clk              single clock, all state updates on the rising edge
//   reset            synchronous, active-low reset (0 = reset)
//   in_valid         an instruction is offered
//   in_ready         the block accepts the offered instruction this cycle
//   Funct[5:0]       [5]=I (immediate), [4:1]=cmd, [0]=S (set flags)
//   ALUOp            1 = data-processing instruction
//   out_valid        decode result at the outputs is valid
//   out_ready        consumer takes the result this cycle
//   ALUControl[3:0]  ALU operation code
//   FlagW[1:0]       flag-write enables, [1]=NZ, [0]=CV
//   NoWrite          destination register write suppressed
//   Illegal          result is an unimplemented opcode
//   illegal_cnt_clr  synchronous clear of illegal_cnt (wins over increment)
//   illegal_cnt      saturating count of accepted illegal ops
//
// Handshake
//   A transfer happens on a rising edge where valid and ready are both 1 on
//   the same side (in_valid&in_ready at the input, out_valid&out_ready at the
//   output). A producer holding valid=1 keeps its data stable until the
//   transfer; ready may depend combinationally on the downstream ready, but
//   valid never depends on ready.
// ---------------------------------------------------------------------------
module dp_decode_pipe #(
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       Funct,
  input  logic             ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ALUControl,
  output logic [1:0]       FlagW,
  output logic             NoWrite,
  output logic             Illegal,
  input  logic             illegal_cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  // ALUControl encodings
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_ADC = 4'b0100;
  localparam logic [3:0] ALU_SBC = 4'b0101;
  localparam logic [3:0] ALU_RSB = 4'b0110;
  localparam logic [3:0] ALU_EOR = 4'b0111;
  localparam logic [3:0] ALU_BIC = 4'b1000;
  localparam logic [3:0] ALU_MOV = 4'b1001;
  localparam logic [3:0] ALU_MVN = 4'b1010;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [3:0] cmd;
  logic       set_flags;
  logic       unused_imm;

  assign cmd        = Funct[4:1];
  assign set_flags  = Funct[0];
  // The immediate bit selects the operand source only; it has no effect on
  // the ALU operation or the flag/write controls.
  assign unused_imm = Funct[5];

  logic [3:0] dec_ctrl;
  logic [1:0] dec_flagw;
  logic       dec_nowrite;
  logic       dec_illegal;
  logic       dec_arith;
  logic       dec_compare;

  always_comb begin
    dec_ctrl    = 4'b0000;
    dec_flagw   = 2'b00;
    dec_nowrite = 1'b0;
    dec_illegal = 1'b0;
    dec_arith   = 1'b0;
    dec_compare = 1'b0;

    if (ALUOp) begin
      unique case (cmd)
        4'b0000: dec_ctrl = ALU_AND;                                // AND
        4'b0001: dec_ctrl = ALU_EOR;                                // EOR
        4'b0010: begin dec_ctrl = ALU_SUB; dec_arith = 1'b1; end    // SUB
        4'b0011: begin dec_ctrl = ALU_RSB; dec_arith = 1'b1; end    // RSB
        4'b0100: begin dec_ctrl = ALU_ADD; dec_arith = 1'b1; end    // ADD
        4'b0101: begin dec_ctrl = ALU_ADC; dec_arith = 1'b1; end    // ADC
        4'b0110: begin dec_ctrl = ALU_SBC; dec_arith = 1'b1; end    // SBC
        4'b0111: dec_illegal = 1'b1;                                // RSC decodes as illegal
        4'b1000: begin dec_ctrl = ALU_AND; dec_compare = 1'b1; end  // TST
        4'b1001: begin dec_ctrl = ALU_EOR; dec_compare = 1'b1; end  // TEQ
        4'b1010: begin                                              // CMP
          dec_ctrl    = ALU_SUB;
          dec_arith   = 1'b1;
          dec_compare = 1'b1;
        end
        4'b1011: begin                                              // CMN
          dec_ctrl    = ALU_ADD;
          dec_arith   = 1'b1;
          dec_compare = 1'b1;
        end
        4'b1100: dec_ctrl = ALU_ORR;                                // ORR
        4'b1101: dec_ctrl = ALU_MOV;                                // MOV
        4'b1110: dec_ctrl = ALU_BIC;                                // BIC
        default: dec_ctrl = ALU_MVN;                                // MVN
      endcase

      // A compare without S has no architectural effect at all and is
      // treated as an unimplemented encoding.
      if (dec_compare && !set_flags) begin
        dec_illegal = 1'b1;
      end

      if (dec_illegal) begin
        // Illegal results are forced to a harmless, fully known payload.
        dec_ctrl    = 4'b0000;
        dec_flagw   = 2'b00;
        dec_nowrite = 1'b1;
      end else if (dec_compare) begin
        dec_nowrite = 1'b1;
        dec_flagw   = {1'b1, dec_arith};
      end else begin
        dec_nowrite = 1'b0;
        dec_flagw   = {set_flags, set_flags & dec_arith};
      end
    end
  end

  // Payload layout: {ALUControl, FlagW, NoWrite, Illegal}
  logic [7:0] dec_pay;
  assign dec_pay = {dec_ctrl, dec_flagw, dec_nowrite, dec_illegal};

  // ---------------------------------------------------------------------------
  // Elastic stages
  // ---------------------------------------------------------------------------
  logic       vld [STAGES];
  logic [7:0] pay [STAGES];
  logic [STAGES-1:0] rdy;
  logic       full_above;
  logic       accept;

  // Stage i can load when it is empty or everything from it to the output
  // drains this cycle. Written as "out_ready or any stage from i onward is
  // empty", which is the unrolled form of rdy[i] = !vld[i] | rdy[i+1] and
  // avoids a bit-to-bit dependency inside one vector.
  always_comb begin
    full_above = 1'b1;
    rdy        = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full_above = full_above & vld[i];
      rdy[i]     = out_ready | ~full_above;
    end
  end

  // Held low in reset so nothing is accepted into a pipe being flushed.
  assign in_ready = reset & rdy[0];
  assign accept   = in_valid & in_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic       src_vld;
    logic [7:0] src_pay;

    if (g == 0) begin : g_head
      assign src_vld = accept;
      assign src_pay = dec_pay;
    end else begin : g_body
      assign src_vld = vld[g-1];
      assign src_pay = pay[g-1];
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        vld[g] <= 1'b0;
        pay[g] <= 8'h00;
      end else if (rdy[g]) begin
        vld[g] <= src_vld;
        // Payload only changes when a real item arrives, so idle outputs
        // keep the last known value instead of toggling.
        if (src_vld) begin
          pay[g] <= src_pay;
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign {ALUControl, FlagW, NoWrite, Illegal} = pay[STAGES-1];

  // ---------------------------------------------------------------------------
  // Illegal-op counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal_cnt <= '0;
    end else if (illegal_cnt_clr) begin
      illegal_cnt <= '0;
    end else if (accept && dec_illegal && !(&illegal_cnt)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dp_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_dp_decode_pipe
//
// Directed bench for dp_decode_pipe with STAGES=2 and a 2-bit illegal
// counter so saturation is reachable. Inputs are driven and outputs sampled
// 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_dp_decode_pipe;

  localparam int STAGES = 2;
  localparam int CNT_W  = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       Funct;
  logic             ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       ALUControl;
  logic [1:0]       FlagW;
  logic             NoWrite;
  logic             Illegal;
  logic             illegal_cnt_clr;
  logic [CNT_W-1:0] illegal_cnt;

  always #5 clk = ~clk;

  dp_decode_pipe #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .Funct           (Funct),
    .ALUOp           (ALUOp),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .ALUControl      (ALUControl),
    .FlagW           (FlagW),
    .NoWrite         (NoWrite),
    .Illegal         (Illegal),
    .illegal_cnt_clr (illegal_cnt_clr),
    .illegal_cnt     (illegal_cnt)
  );

  int checks = 0;
  int passed = 0;

  // Scoreboard of expected ALUControl values in issue order.
  logic [3:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic aluop, input logic [5:0] funct);
    in_valid = 1'b1;
    ALUOp    = aluop;
    Funct    = funct;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    ALUOp    = 1'b0;
    Funct    = 6'b000000;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b1; illegal_cnt_clr = 1'b0;
    drive_idle();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
    checks++; if (ALUControl !== 4'b0000) $display("FAIL reset_alucontrol got=%b exp=0000", ALUControl); else passed++;
    checks++; if (FlagW !== 2'b00) $display("FAIL reset_flagw got=%b exp=00", FlagW); else passed++;
    checks++; if (NoWrite !== 1'b0) $display("FAIL reset_nowrite got=%b exp=0", NoWrite); else passed++;
    checks++; if (Illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", Illegal); else passed++;
    checks++; if (illegal_cnt !== 2'd0) $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", in_ready); else passed++;
  endtask

  // Each entry: {ALUOp, Funct[5:0], ALUControl, FlagW, NoWrite, Illegal}
  task automatic test_decode();
    logic [14:0] vec [18];
    vec = '{
      {1'b1, 6'b001001, 4'b0000, 2'b11, 1'b0, 1'b0},  // ADD  S
      {1'b1, 6'b010101, 4'b0001, 2'b11, 1'b1, 1'b0},  // CMP  S
      {1'b1, 6'b010001, 4'b0010, 2'b10, 1'b1, 1'b0},  // TST  S
      {1'b1, 6'b010011, 4'b0111, 2'b10, 1'b1, 1'b0},  // TEQ  S
      {1'b1, 6'b010111, 4'b0000, 2'b11, 1'b1, 1'b0},  // CMN  S
      {1'b1, 6'b000000, 4'b0010, 2'b00, 1'b0, 1'b0},  // AND
      {1'b1, 6'b000011, 4'b0111, 2'b10, 1'b0, 1'b0},  // EOR  S
      {1'b1, 6'b100101, 4'b0001, 2'b11, 1'b0, 1'b0},  // SUB  S, I=1
      {1'b1, 6'b000111, 4'b0110, 2'b11, 1'b0, 1'b0},  // RSB  S
      {1'b1, 6'b001011, 4'b0100, 2'b11, 1'b0, 1'b0},  // ADC  S
      {1'b1, 6'b001101, 4'b0101, 2'b11, 1'b0, 1'b0},  // SBC  S
      {1'b1, 6'b011001, 4'b0011, 2'b10, 1'b0, 1'b0},  // ORR  S
      {1'b1, 6'b011010, 4'b1001, 2'b00, 1'b0, 1'b0},  // MOV
      {1'b1, 6'b011101, 4'b1000, 2'b10, 1'b0, 1'b0},  // BIC  S
      {1'b1, 6'b111111, 4'b1010, 2'b10, 1'b0, 1'b0},  // MVN  S, I=1
      {1'b1, 6'b001000, 4'b0000, 2'b00, 1'b0, 1'b0},  // ADD
      {1'b0, 6'b010100, 4'b0000, 2'b00, 1'b0, 1'b0},  // not DP (CMP S=0 pattern)
      {1'b0, 6'b001110, 4'b0000, 2'b00, 1'b0, 1'b0}   // not DP (RSC pattern)
    };
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      drive_op(vec[k][14], vec[k][13:8]);
      tick();
      drive_idle();
      checks++; if (out_valid !== 1'b0) $display("FAIL dec%0d_early_valid got=%b exp=0", k, out_valid); else passed++;
      tick();
      checks++; if (out_valid !== 1'b1) $display("FAIL dec%0d_out_valid got=%b exp=1", k, out_valid); else passed++;
      checks++; if (ALUControl !== vec[k][7:4]) $display("FAIL dec%0d_alucontrol got=%b exp=%b", k, ALUControl, vec[k][7:4]); else passed++;
      checks++; if (FlagW !== vec[k][3:2]) $display("FAIL dec%0d_flagw got=%b exp=%b", k, FlagW, vec[k][3:2]); else passed++;
      checks++; if (NoWrite !== vec[k][1]) $display("FAIL dec%0d_nowrite got=%b exp=%b", k, NoWrite, vec[k][1]); else passed++;
      checks++; if (Illegal !== vec[k][0]) $display("FAIL dec%0d_illegal got=%b exp=%b", k, Illegal, vec[k][0]); else passed++;
    end
    tick();
    checks++; if (illegal_cnt !== 2'd0) $display("FAIL dec_cnt got=%0d exp=0", illegal_cnt); else passed++;
  endtask

  task automatic test_illegal();
    logic [5:0] ill_f [2];
    ill_f = '{6'b001110, 6'b010100};  // RSC, CMP with S=0
    out_ready = 1'b1;
    drive_op(1'b1, ill_f[0]);
    tick();
    checks++; if (illegal_cnt !== 2'd1) $display("FAIL ill_cnt1 got=%0d exp=1", illegal_cnt); else passed++;
    drive_op(1'b1, ill_f[1]);
    tick();
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_valid !== 1'b1) $display("FAIL ill%0d_out_valid got=%b exp=1", k, out_valid); else passed++;
      checks++; if (Illegal !== 1'b1) $display("FAIL ill%0d_illegal got=%b exp=1", k, Illegal); else passed++;
      checks++; if (ALUControl !== 4'b0000) $display("FAIL ill%0d_alucontrol got=%b exp=0000", k, ALUControl); else passed++;
      checks++; if (FlagW !== 2'b00) $display("FAIL ill%0d_flagw got=%b exp=00", k, FlagW); else passed++;
      checks++; if (NoWrite !== 1'b1) $display("FAIL ill%0d_nowrite got=%b exp=1", k, NoWrite); else passed++;
      tick();
    end
    checks++; if (illegal_cnt !== 2'd2) $display("FAIL ill_cnt2 got=%0d exp=2", illegal_cnt); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL ill_drained got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] f [6];
    logic [3:0] c [6];
    f = '{6'b011000, 6'b011010, 6'b011100, 6'b000010, 6'b001100, 6'b000110};
    c = '{4'b0011,   4'b1001,   4'b1000,   4'b0111,   4'b0101,   4'b0110};
    out_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) drive_op(1'b1, f[k]);
      else drive_idle();
      checks++; if (in_ready !== 1'b1) $display("FAIL b2b%0d_in_ready got=%b exp=1", k, in_ready); else passed++;
      tick();
      if (k >= 1) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b%0d_out_valid got=%b exp=1", k, out_valid); else passed++;
        checks++; if (ALUControl !== c[k-1]) $display("FAIL b2b%0d_alucontrol got=%b exp=%b", k, ALUControl, c[k-1]); else passed++;
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    logic [5:0] f [6];
    logic [3:0] c [6];
    int         sent;
    int         got;
    int         occ;
    logic       held_v;
    logic [7:0] held;
    logic       saw_stall;
    logic       exp_ready;
    logic       acc;
    f = '{6'b001001, 6'b100101, 6'b000001, 6'b011000, 6'b001011, 6'b001101};
    c = '{4'b0000,   4'b0001,   4'b0010,   4'b0011,   4'b0100,   4'b0101};
    sent = 0; got = 0; held_v = 1'b0; held = 8'h00; saw_stall = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 7);
      if (sent < 6) drive_op(1'b1, f[sent]);
      else drive_idle();
      #1;
      occ = sent - got;
      exp_ready = !(occ == STAGES && !out_ready);
      checks++; if (in_ready !== exp_ready) $display("FAIL bp%0d_in_ready got=%b exp=%b", cyc, in_ready, exp_ready); else passed++;
      if (!in_ready) saw_stall = 1'b1;
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || {ALUControl, FlagW, NoWrite, Illegal} !== held)
          $display("FAIL bp%0d_hold got=%b/%h exp=1/%h", cyc, out_valid, {ALUControl, FlagW, NoWrite, Illegal}, held);
        else passed++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL bp%0d_extra got=%b exp=none", cyc, ALUControl);
        else if (ALUControl !== exp_q[0]) $display("FAIL bp%0d_order got=%b exp=%b", cyc, ALUControl, exp_q[0]);
        else passed++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      held_v = out_valid && !out_ready;
      held   = {ALUControl, FlagW, NoWrite, Illegal};
      acc    = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(c[sent]);
        sent++;
      end
      tick();
    end
    drive_idle();
    out_ready = 1'b1;
    checks++; if (got != 6) $display("FAIL bp_count got=%0d exp=6", got); else passed++;
    checks++; if (saw_stall !== 1'b1) $display("FAIL bp_stall got=%b exp=1", saw_stall); else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL bp_leftover got=%0d exp=0", exp_q.size()); else passed++;
  endtask

  task automatic test_counter();
    int exp_cnt;
    out_ready = 1'b1;
    illegal_cnt_clr = 1'b1;
    tick();
    illegal_cnt_clr = 1'b0;
    checks++; if (illegal_cnt !== 2'd0) $display("FAIL cnt_clr got=%0d exp=0", illegal_cnt); else passed++;
    for (int n = 1; n <= 5; n++) begin
      drive_op(1'b1, 6'b001110);
      tick();
      exp_cnt = (n > 3) ? 3 : n;
      checks++; if (illegal_cnt !== exp_cnt[CNT_W-1:0]) $display("FAIL cnt_inc%0d got=%0d exp=%0d", n, illegal_cnt, exp_cnt); else passed++;
    end
    // Clear and an illegal accept in the same cycle: the clear wins.
    illegal_cnt_clr = 1'b1;
    drive_op(1'b1, 6'b001110);
    tick();
    illegal_cnt_clr = 1'b0;
    drive_idle();
    checks++; if (illegal_cnt !== 2'd0) $display("FAIL cnt_clr_wins got=%0d exp=0", illegal_cnt); else passed++;
    tick(); tick();
    drive_op(1'b1, 6'b010100);
    tick();
    drive_idle();
    checks++; if (illegal_cnt !== 2'd1) $display("FAIL cnt_after_clr got=%0d exp=1", illegal_cnt); else passed++;
    tick(); tick();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive_op(1'b1, 6'b001110);  // RSC, illegal
    tick();
    drive_op(1'b1, 6'b011010);  // MOV
    tick();
    drive_idle();
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL mr_full_valid got=%b exp=1", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL mr_full_ready got=%b exp=0", in_ready); else passed++;
    checks++; if (illegal_cnt !== 2'd2) $display("FAIL mr_cnt_before got=%0d exp=2", illegal_cnt); else passed++;
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL mr_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if (illegal_cnt !== 2'd0) $display("FAIL mr_cnt got=%0d exp=0", illegal_cnt); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL mr_in_ready got=%b exp=0", in_ready); else passed++;
    checks++; if (Illegal !== 1'b0) $display("FAIL mr_illegal got=%b exp=0", Illegal); else passed++;
    reset = 1'b1;
    out_ready = 1'b1;
    drive_op(1'b1, 6'b011101);  // BIC S
    tick();
    drive_idle();
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL mr_first_valid got=%b exp=1", out_valid); else passed++;
    checks++; if (ALUControl !== 4'b1000) $display("FAIL mr_first_alucontrol got=%b exp=1000", ALUControl); else passed++;
    checks++; if (FlagW !== 2'b10) $display("FAIL mr_first_flagw got=%b exp=10", FlagW); else passed++;
    checks++; if (Illegal !== 1'b0) $display("FAIL mr_first_illegal got=%b exp=0", Illegal); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL mr_no_stale got=%b exp=0", out_valid); else passed++;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    illegal_cnt_clr = 1'b0;
    drive_idle();
    test_reset();
    test_decode();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_counter();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
